// File: rtl/operand_collector_pkg.sv
// Shared GPU instruction header: the instruction word carried through the
// operand collector unchanged.
package operand_collector_pkg;

  typedef struct packed {
    logic [5:0] opcode;
    logic [1:0] fmt;
    logic [7:0] imm;
  } bgpu_inst_t;

endpackage

// File: rtl/operand_collector.sv
// Operand collector: accepts one instruction, reads its source registers one
// at a time from the register file, then presents the gathered operands.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int NumTags         = 8,
  parameter int PcWidth         = 32,
  parameter int WarpWidth       = 32,
  parameter int RegIdxWidth     = 6,
  parameter int OperandsPerInst = 2,
  parameter int RegWidth        = 32
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,

  output logic                                                  opc_ready_o,
  input  logic                                                  disp_valid_i,
  input  logic [$clog2(NumTags)-1:0]                            disp_tag_i,
  input  logic [PcWidth-1:0]                                    disp_pc_i,
  input  logic [WarpWidth-1:0]                                  disp_act_mask_i,
  input  bgpu_inst_t                                            disp_inst_i,
  input  logic [RegIdxWidth-1:0]                                disp_dst_i,
  input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0]           disp_operands_i,

  output logic                                                  opc_rf_req_valid_o,
  input  logic                                                  rf_req_ready_i,
  output logic [RegIdxWidth-1:0]                                opc_rf_req_reg_o,
  input  logic                                                  rf_rsp_valid_i,
  input  logic [WarpWidth*RegWidth-1:0]                         rf_rsp_data_i,

  input  logic                                                  eu_ready_i,
  output logic                                                  opc_valid_o,
  output logic [$clog2(NumTags)-1:0]                            opc_tag_o,
  output logic [PcWidth-1:0]                                    opc_pc_o,
  output logic [WarpWidth-1:0]                                  opc_act_mask_o,
  output bgpu_inst_t                                            opc_inst_o,
  output logic [RegIdxWidth-1:0]                                opc_dst_o,
  output logic [OperandsPerInst-1:0][WarpWidth*RegWidth-1:0]    opc_operand_data_o
);

  localparam int TagWidth = $clog2(NumTags);
  localparam int IdxWidth = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(OperandsPerInst - 1);

  typedef logic [TagWidth-1:0]              tag_t;
  typedef logic [RegIdxWidth-1:0]           reg_idx_t;
  typedef logic [PcWidth-1:0]               pc_t;
  typedef logic [WarpWidth-1:0]             act_mask_t;
  typedef logic [WarpWidth*RegWidth-1:0]    data_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;

  state_e                                  state_q;
  logic [IdxWidth-1:0]                     idx_q;
  tag_t                                    tag_q;
  pc_t                                     pc_q;
  act_mask_t                               mask_q;
  bgpu_inst_t                              inst_q;
  reg_idx_t                                dst_q;
  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] operands_q;
  logic [OperandsPerInst-1:0][WarpWidth*RegWidth-1:0] opnd_data_q;

  logic disp_hs;

  // Ready in OUT only when the current instruction leaves this same cycle,
  // which lets a new instruction overlap the hand-off to the execution unit.
  assign opc_ready_o = (state_q == IDLE) || ((state_q == OUT) && eu_ready_i);
  assign disp_hs     = disp_valid_i && opc_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tag_q       <= '0;
      pc_q        <= '0;
      mask_q      <= '0;
      inst_q      <= '0;
      dst_q       <= '0;
      operands_q  <= '0;
      opnd_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (disp_hs) begin
            tag_q      <= disp_tag_i;
            pc_q       <= disp_pc_i;
            mask_q     <= disp_act_mask_i;
            inst_q     <= disp_inst_i;
            dst_q      <= disp_dst_i;
            operands_q <= disp_operands_i;
            idx_q      <= '0;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (rf_req_ready_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (rf_rsp_valid_i) begin
            opnd_data_q[idx_q] <= rf_rsp_data_i;
            if (idx_q == LastIdx) begin
              state_q <= OUT;
            end else begin
              idx_q   <= idx_q + IdxWidth'(1);
              state_q <= REQ;
            end
          end
        end
        OUT: begin
          if (disp_hs) begin
            tag_q      <= disp_tag_i;
            pc_q       <= disp_pc_i;
            mask_q     <= disp_act_mask_i;
            inst_q     <= disp_inst_i;
            dst_q      <= disp_dst_i;
            operands_q <= disp_operands_i;
            idx_q      <= '0;
            state_q    <= REQ;
          end else if (eu_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opc_rf_req_valid_o = (state_q == REQ);
  assign opc_rf_req_reg_o   = operands_q[idx_q];

  assign opc_valid_o        = (state_q == OUT);
  assign opc_tag_o          = tag_q;
  assign opc_pc_o           = pc_q;
  assign opc_act_mask_o     = mask_q;
  assign opc_inst_o         = inst_q;
  assign opc_dst_o          = dst_q;
  assign opc_operand_data_o = opnd_data_q;

`ifndef SYNTHESIS
  a_no_rsp_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == IDLE) |-> !rf_rsp_valid_i)
    else $warning("operand_collector: rf_rsp_valid_i while idle");

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (opc_valid_o && !eu_ready_i) |=>
      (opc_valid_o && $stable(opc_tag_o) && $stable(opc_pc_o) &&
       $stable(opc_act_mask_o) && $stable(opc_inst_o) && $stable(opc_dst_o) &&
       $stable(opc_operand_data_o)))
    else $error("operand_collector: payload changed while stalled");
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: a cycle-stepped register-file
// responder plus one task per scenario, each with hand-computed expectations.
module tb_operand_collector;
  import operand_collector_pkg::*;

  localparam int DW = 32 * 32;
  typedef logic [DW-1:0] data_t;
  typedef logic [1:0][DW-1:0] opnd_t;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic                 opc_ready_o;
  logic                 disp_valid_i;
  logic [2:0]           disp_tag_i;
  logic [31:0]          disp_pc_i;
  logic [31:0]          disp_act_mask_i;
  bgpu_inst_t           disp_inst_i;
  logic [5:0]           disp_dst_i;
  logic [1:0][5:0]      disp_operands_i;
  logic                 opc_rf_req_valid_o;
  logic                 rf_req_ready_i;
  logic [5:0]           opc_rf_req_reg_o;
  logic                 rf_rsp_valid_i;
  data_t                rf_rsp_data_i;
  logic                 eu_ready_i;
  logic                 opc_valid_o;
  logic [2:0]           opc_tag_o;
  logic [31:0]          opc_pc_o;
  logic [31:0]          opc_act_mask_o;
  bgpu_inst_t           opc_inst_o;
  logic [5:0]           opc_dst_o;
  opnd_t                opc_operand_data_o;

  int checks = 0;
  int failures = 0;

  operand_collector dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .opc_ready_o        (opc_ready_o),
    .disp_valid_i       (disp_valid_i),
    .disp_tag_i         (disp_tag_i),
    .disp_pc_i          (disp_pc_i),
    .disp_act_mask_i    (disp_act_mask_i),
    .disp_inst_i        (disp_inst_i),
    .disp_dst_i         (disp_dst_i),
    .disp_operands_i    (disp_operands_i),
    .opc_rf_req_valid_o (opc_rf_req_valid_o),
    .rf_req_ready_i     (rf_req_ready_i),
    .opc_rf_req_reg_o   (opc_rf_req_reg_o),
    .rf_rsp_valid_i     (rf_rsp_valid_i),
    .rf_rsp_data_i      (rf_rsp_data_i),
    .eu_ready_i         (eu_ready_i),
    .opc_valid_o        (opc_valid_o),
    .opc_tag_o          (opc_tag_o),
    .opc_pc_o           (opc_pc_o),
    .opc_act_mask_o     (opc_act_mask_o),
    .opc_inst_o         (opc_inst_o),
    .opc_dst_o          (opc_dst_o),
    .opc_operand_data_o (opc_operand_data_o)
  );

  always #5 clk = ~clk;

  function automatic data_t mk(input logic [31:0] base);
    data_t d;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = base + 32'(i);
    return d;
  endfunction

  data_t dA, dB, dC, dD, dDead;
  bgpu_inst_t inst1, inst5;

  // All tasks start and end on a negative edge; inputs change there and
  // outputs are sampled there, half a period away from the active edge.
  task automatic dispatch(input logic [2:0] tag, input logic [31:0] pc,
                          input logic [31:0] mask, input bgpu_inst_t inst,
                          input logic [5:0] dst, input logic [5:0] op0,
                          input logic [5:0] op1);
    disp_valid_i = 1'b1;
    disp_tag_i = tag;
    disp_pc_i = pc;
    disp_act_mask_i = mask;
    disp_inst_i = inst;
    disp_dst_i = dst;
    disp_operands_i = {op1, op0};
    @(posedge clk);
    @(negedge clk);
    disp_valid_i = 1'b0;
  endtask

  // Latency counts clock edges from the handshake edge (counted as 1) up to
  // and including the edge after which opc_valid_o is seen. The responder
  // returns data in the cycle right after each accepted request.
  task automatic collect(input int stall, input bit spur, input data_t d0,
                         input data_t d1, output int lat, output int nreq,
                         output logic [1:0][5:0] regs,
                         output logic [3:0][5:0] sregs);
    bit pending;
    int rsp_cnt;
    int s;
    int st;
    lat = 1; nreq = 0; pending = 0; rsp_cnt = 0; st = 0; s = stall;
    regs = '0; sregs = '0;
    for (int c = 0; c < 60 && !opc_valid_o; c++) begin
      rf_rsp_valid_i = pending;
      rf_rsp_data_i = (rsp_cnt == 0) ? d0 : d1;
      if (pending) rsp_cnt++;
      else if (spur && opc_rf_req_valid_o) begin
        rf_rsp_valid_i = 1'b1;
        rf_rsp_data_i = dDead;
      end
      pending = 0;
      rf_req_ready_i = 1'b1;
      if (opc_rf_req_valid_o) begin
        if (s > 0) begin
          rf_req_ready_i = 1'b0;
          if (st < 4) sregs[st] = opc_rf_req_reg_o;
          st++;
          s--;
        end else begin
          if (nreq < 2) regs[nreq] = opc_rf_req_reg_o;
          nreq++;
          pending = 1;
        end
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rf_rsp_valid_i = 1'b0;
    rf_req_ready_i = 1'b0;
    if (!opc_valid_o) lat = -1;
  endtask

  task automatic consume();
    eu_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    eu_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (opc_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", opc_ready_o); end
    checks++;
    if (opc_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", opc_valid_o); end
    checks++;
    if (opc_rf_req_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rfreq got=%b exp=0", opc_rf_req_valid_o); end
    checks++;
    if ({opc_tag_o, opc_pc_o, opc_act_mask_o, opc_inst_o, opc_dst_o} !== '0) begin
      failures++; $display("[TB] FAIL reset_payload got tag=%h pc=%h mask=%h exp=0", opc_tag_o, opc_pc_o, opc_act_mask_o);
    end
    checks++;
    if (opc_operand_data_o !== '0) begin
      failures++; $display("[TB] FAIL reset_data got_lo=%h exp=0", opc_operand_data_o[0][63:0]);
    end
  endtask

  task automatic test_single();
    int lat, nreq;
    logic [1:0][5:0] regs;
    logic [3:0][5:0] sregs;
    opnd_t exp;
    exp = {dB, dA};
    dispatch(3'd1, 32'h0000_0100, 32'hFFFF_0000, inst1, 6'd9, 6'd3, 6'd7);
    collect(0, 1'b0, dA, dB, lat, nreq, regs, sregs);
    checks++;
    if (lat !== 5) begin failures++; $display("[TB] FAIL single_latency got=%0d exp=5", lat); end
    checks++;
    if (opc_operand_data_o !== exp) begin
      failures++; $display("[TB] FAIL single_data got=%h_%h exp=%h_%h", opc_operand_data_o[1][31:0], opc_operand_data_o[0][31:0], exp[1][31:0], exp[0][31:0]);
    end
    checks++;
    if (opc_tag_o !== 3'd1 || opc_pc_o !== 32'h0000_0100 || opc_act_mask_o !== 32'hFFFF_0000) begin
      failures++; $display("[TB] FAIL single_meta got tag=%0d pc=%h mask=%h exp tag=1 pc=100 mask=ffff0000", opc_tag_o, opc_pc_o, opc_act_mask_o);
    end
    checks++;
    if (opc_inst_o !== inst1 || opc_dst_o !== 6'd9) begin
      failures++; $display("[TB] FAIL single_inst got inst=%h dst=%0d exp inst=%h dst=9", opc_inst_o, opc_dst_o, inst1);
    end
    checks++;
    if (regs !== {6'd7, 6'd3} || nreq !== 2) begin
      failures++; $display("[TB] FAIL single_reqs got regs=%0d,%0d n=%0d exp 3,7 n=2", regs[0], regs[1], nreq);
    end
    consume();
    checks++;
    if (opc_valid_o !== 1'b0 || opc_ready_o !== 1'b1) begin
      failures++; $display("[TB] FAIL single_release got valid=%b ready=%b exp 0/1", opc_valid_o, opc_ready_o);
    end
  endtask

  task automatic test_rf_stall();
    int lat, nreq;
    logic [1:0][5:0] regs;
    logic [3:0][5:0] sregs;
    opnd_t exp;
    exp = {dB, dA};
    dispatch(3'd1, 32'h0000_0100, 32'hFFFF_0000, inst1, 6'd9, 6'd3, 6'd7);
    collect(4, 1'b0, dA, dB, lat, nreq, regs, sregs);
    checks++;
    if (lat !== 9) begin failures++; $display("[TB] FAIL stall_latency got=%0d exp=9", lat); end
    checks++;
    if (sregs !== {4{6'd3}}) begin
      failures++; $display("[TB] FAIL stall_reg got=%0d,%0d,%0d,%0d exp=3,3,3,3", sregs[0], sregs[1], sregs[2], sregs[3]);
    end
    checks++;
    if (nreq !== 2 || regs !== {6'd7, 6'd3}) begin
      failures++; $display("[TB] FAIL stall_accepts got n=%0d regs=%0d,%0d exp n=2 regs=3,7", nreq, regs[0], regs[1]);
    end
    checks++;
    if (opc_operand_data_o !== exp) begin
      failures++; $display("[TB] FAIL stall_data got=%h_%h exp=%h_%h", opc_operand_data_o[1][31:0], opc_operand_data_o[0][31:0], exp[1][31:0], exp[0][31:0]);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, nreq;
    logic [1:0][5:0] regs;
    logic [3:0][5:0] sregs;
    opnd_t exp3, exp5;
    exp3 = {dB, dA};
    exp5 = {dD, dC};
    dispatch(3'd3, 32'h0000_0200, 32'h0000_FFFF, inst1, 6'd4, 6'd3, 6'd7);
    collect(0, 1'b0, dA, dB, lat, nreq, regs, sregs);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (opc_valid_o !== 1'b1 || opc_ready_o !== 1'b0) begin
        failures++; $display("[TB] FAIL hold_handshake cyc=%0d got valid=%b ready=%b exp 1/0", i, opc_valid_o, opc_ready_o);
      end
      checks++;
      if (opc_tag_o !== 3'd3 || opc_pc_o !== 32'h0000_0200 || opc_operand_data_o !== exp3) begin
        failures++; $display("[TB] FAIL hold_payload cyc=%0d got tag=%0d pc=%h d0=%h exp tag=3 pc=200 d0=%h", i, opc_tag_o, opc_pc_o, opc_operand_data_o[0][31:0], exp3[0][31:0]);
      end
    end
    eu_ready_i = 1'b1;
    disp_valid_i = 1'b1;
    disp_tag_i = 3'd5;
    disp_pc_i = 32'h0000_0300;
    disp_act_mask_i = 32'h0F0F_0F0F;
    disp_inst_i = inst5;
    disp_dst_i = 6'd12;
    disp_operands_i = {6'd21, 6'd20};
    #1;
    checks++;
    if (opc_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready got=%b exp=1", opc_ready_o); end
    @(posedge clk);
    @(negedge clk);
    disp_valid_i = 1'b0;
    eu_ready_i = 1'b0;
    checks++;
    if (opc_valid_o !== 1'b0 || opc_rf_req_valid_o !== 1'b1 || opc_rf_req_reg_o !== 6'd20) begin
      failures++; $display("[TB] FAIL b2b_accept got valid=%b rfreq=%b reg=%0d exp 0/1/20", opc_valid_o, opc_rf_req_valid_o, opc_rf_req_reg_o);
    end
    collect(0, 1'b0, dC, dD, lat, nreq, regs, sregs);
    checks++;
    if (lat !== 5 || opc_tag_o !== 3'd5 || opc_dst_o !== 6'd12 || opc_inst_o !== inst5) begin
      failures++; $display("[TB] FAIL b2b_second got lat=%0d tag=%0d dst=%0d exp lat=5 tag=5 dst=12", lat, opc_tag_o, opc_dst_o);
    end
    checks++;
    if (opc_operand_data_o !== exp5) begin
      failures++; $display("[TB] FAIL b2b_data got=%h_%h exp=%h_%h", opc_operand_data_o[1][31:0], opc_operand_data_o[0][31:0], exp5[1][31:0], exp5[0][31:0]);
    end
    consume();
  endtask

  task automatic test_spurious();
    int lat, nreq;
    logic [1:0][5:0] regs;
    logic [3:0][5:0] sregs;
    opnd_t prev, exp;
    prev = {dD, dC};
    exp = {dB, dA};
    rf_rsp_valid_i = 1'b1;
    rf_rsp_data_i = dDead;
    @(posedge clk);
    @(negedge clk);
    rf_rsp_valid_i = 1'b0;
    checks++;
    if (opc_ready_o !== 1'b1 || opc_valid_o !== 1'b0 || opc_rf_req_valid_o !== 1'b0 || opc_operand_data_o !== prev) begin
      failures++; $display("[TB] FAIL spur_idle got ready=%b valid=%b rfreq=%b d0=%h exp 1/0/0 d0=%h", opc_ready_o, opc_valid_o, opc_rf_req_valid_o, opc_operand_data_o[0][31:0], prev[0][31:0]);
    end
    dispatch(3'd6, 32'h0000_0400, 32'hFFFF_FFFF, inst1, 6'd1, 6'd3, 6'd7);
    collect(0, 1'b1, dA, dB, lat, nreq, regs, sregs);
    checks++;
    if (lat !== 5 || opc_operand_data_o !== exp) begin
      failures++; $display("[TB] FAIL spur_req got lat=%0d data=%h_%h exp lat=5 data=%h_%h", lat, opc_operand_data_o[1][31:0], opc_operand_data_o[0][31:0], exp[1][31:0], exp[0][31:0]);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat, nreq;
    logic [1:0][5:0] regs;
    logic [3:0][5:0] sregs;
    opnd_t exp;
    exp = {dD, dC};
    dispatch(3'd4, 32'h0000_0500, 32'hAAAA_AAAA, inst5, 6'd8, 6'd3, 6'd7);
    rf_req_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    rf_req_ready_i = 1'b0;
    rf_rsp_valid_i = 1'b1;
    rf_rsp_data_i = dA;
    @(posedge clk); @(negedge clk);
    rf_rsp_valid_i = 1'b0;
    rf_req_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    rf_req_ready_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (opc_ready_o !== 1'b1 || opc_valid_o !== 1'b0 || opc_rf_req_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_ctrl got ready=%b valid=%b rfreq=%b exp 1/0/0", opc_ready_o, opc_valid_o, opc_rf_req_valid_o);
    end
    checks++;
    if ({opc_tag_o, opc_pc_o, opc_act_mask_o, opc_inst_o, opc_dst_o} !== '0 || opc_operand_data_o !== '0) begin
      failures++; $display("[TB] FAIL midrst_payload got tag=%0d pc=%h d0=%h exp 0", opc_tag_o, opc_pc_o, opc_operand_data_o[0][31:0]);
    end
    @(posedge clk); @(negedge clk);
    rst_ni = 1'b1;
    rf_rsp_valid_i = 1'b1;
    rf_rsp_data_i = dB;
    @(posedge clk); @(negedge clk);
    rf_rsp_valid_i = 1'b0;
    checks++;
    if (opc_ready_o !== 1'b1 || opc_valid_o !== 1'b0 || opc_rf_req_valid_o !== 1'b0 || opc_operand_data_o !== '0) begin
      failures++; $display("[TB] FAIL midrst_late_rsp got ready=%b valid=%b rfreq=%b d1=%h exp 1/0/0/0", opc_ready_o, opc_valid_o, opc_rf_req_valid_o, opc_operand_data_o[1][31:0]);
    end
    dispatch(3'd2, 32'h0000_0600, 32'h1234_5678, inst1, 6'd2, 6'd10, 6'd11);
    collect(0, 1'b0, dC, dD, lat, nreq, regs, sregs);
    checks++;
    if (lat !== 5 || opc_tag_o !== 3'd2 || opc_pc_o !== 32'h0000_0600 || opc_act_mask_o !== 32'h1234_5678) begin
      failures++; $display("[TB] FAIL midrst_next got lat=%0d tag=%0d pc=%h mask=%h exp lat=5 tag=2 pc=600 mask=12345678", lat, opc_tag_o, opc_pc_o, opc_act_mask_o);
    end
    checks++;
    if (opc_operand_data_o !== exp || regs !== {6'd11, 6'd10}) begin
      failures++; $display("[TB] FAIL midrst_data got=%h_%h regs=%0d,%0d exp=%h_%h regs=10,11", opc_operand_data_o[1][31:0], opc_operand_data_o[0][31:0], regs[0], regs[1], exp[1][31:0], exp[0][31:0]);
    end
    consume();
  endtask

  initial begin
    dA = mk(32'hA000_0000);
    dB = mk(32'hB000_0000);
    dC = mk(32'hC000_0000);
    dD = mk(32'hD000_0000);
    dDead = {32{32'h0000_DEAD}};
    inst1 = '{opcode: 6'h12, fmt: 2'd1, imm: 8'h34};
    inst5 = '{opcode: 6'h2A, fmt: 2'd3, imm: 8'hC5};
    rst_ni = 1'b0;
    disp_valid_i = 1'b0;
    disp_tag_i = '0;
    disp_pc_i = '0;
    disp_act_mask_i = '0;
    disp_inst_i = '0;
    disp_dst_i = '0;
    disp_operands_i = '0;
    rf_req_ready_i = 1'b0;
    rf_rsp_valid_i = 1'b0;
    rf_rsp_data_i = '0;
    eu_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_ni = 1'b1;
    @(negedge clk);
    test_single();
    test_rf_stall();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
